// File: rtl/ring_counter_pkg.sv
// Shared constants and seed helper for the parametrised ring/Johnson counter.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    // Returned at full 32-bit width; callers truncate to their WIDTH.
    function automatic logic [31:0] seed_of(input logic mode, input logic [31:0] ring_seed);
        return (mode == MODE_JOHNSON) ? 32'd0 : ring_seed;
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality detector for ring (one-hot) and Johnson codes.
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    output logic             legal
);

    logic [WIDTH-2:0] edges;

    // A Johnson code has at most one boundary between its run of ones and zeros.
    assign edges = count[WIDTH-2:0] ^ count[WIDTH-1:1];

    always_comb begin
        legal = 1'b0;
        if (mode == MODE_RING)
            legal = ($countones(count) == 1);
        else
            legal = ($countones(edges) <= 1);
    end

endmodule

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter with load, wrap pulse and self-correction.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RING_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err
);

    logic             mode_q;
    logic             legal;
    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] seed_new;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             err_nxt;
    logic             mode_nxt;

    assign seed_cur = WIDTH'(seed_of(mode_q, 32'(RING_SEED)));
    assign seed_new = WIDTH'(seed_of(mode, 32'(RING_SEED)));

    // Legality is judged against the mode the current count was built in.
    ring_state_check #(.WIDTH(WIDTH)) u_check (
        .count (count),
        .mode  (mode_q),
        .legal (legal)
    );

    always_comb begin
        stepped = count;
        if (mode_q == MODE_RING) begin
            if (dir == DIR_LEFT)
                stepped = {count[WIDTH-2:0], count[WIDTH-1]};
            else
                stepped = {count[0], count[WIDTH-1:1]};
        end else begin
            if (dir == DIR_LEFT)
                stepped = {count[WIDTH-2:0], ~count[WIDTH-1]};
            else
                stepped = {~count[0], count[WIDTH-1:1]};
        end
    end

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        mode_nxt  = mode_q;
        if (load) begin
            count_nxt = load_val;
        end else if (mode != mode_q) begin
            count_nxt = seed_new;
            mode_nxt  = mode;
        end else if (!legal) begin
            count_nxt = seed_cur;
            err_nxt   = 1'b1;
        end else if (en) begin
            count_nxt = stepped;
            wrap_nxt  = (stepped == seed_cur);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= seed_new;
            wrap   <= 1'b0;
            err    <= 1'b0;
            mode_q <= mode;
        end else begin
            count  <= count_nxt;
            wrap   <= wrap_nxt;
            err    <= err_nxt;
            mode_q <= mode_nxt;
        end
    end

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed bench for ring_counter_param at WIDTH 4 and WIDTH 8.
module tb_ring_counter_param;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load;
    logic [3:0] load_val, count;
    logic       wrap, err;

    logic       rst8, en8, mode8, dir8, load8;
    logic [7:0] load_val8, count8;
    logic       wrap8, err8, legal8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ring_counter_param #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .count(count), .wrap(wrap), .err(err)
    );

    ring_counter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .dir(dir8), .load(load8),
        .load_val(load_val8), .count(count8), .wrap(wrap8), .err(err8)
    );

    ring_state_check #(.WIDTH(8)) chk8 (.count(count8), .mode(mode8), .legal(legal8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; mode = 0; dir = 0; load = 0; load_val = 4'b0000;
        tick(); tick();
        total++; if (count !== 4'b0001) $display("FAIL reset_count got %b want 0001", count); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
    endtask

    task automatic test_ring_left();
        logic [3:0] exp_c [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 0; en = 1; mode = 0; dir = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (count !== exp_c[i]) $display("FAIL ring_left_count[%0d] got %b want %b", i, count, exp_c[i]); else passed++;
            total++; if (wrap !== exp_w[i]) $display("FAIL ring_left_wrap[%0d] got %b want %b", i, wrap, exp_w[i]); else passed++;
        end
    endtask

    task automatic test_ring_right();
        logic [3:0] exp_c [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        dir = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (count !== exp_c[i]) $display("FAIL ring_right_count[%0d] got %b want %b", i, count, exp_c[i]); else passed++;
            total++; if (wrap !== exp_w[i]) $display("FAIL ring_right_wrap[%0d] got %b want %b", i, wrap, exp_w[i]); else passed++;
        end
    endtask

    task automatic test_dir_toggle();
        logic       dirs  [3] = '{1'b1, 1'b0, 1'b0};
        logic [3:0] exp_c [3] = '{4'b1000, 4'b0001, 4'b0010};
        logic       exp_w [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            dir = dirs[i];
            tick();
            total++; if (count !== exp_c[i]) $display("FAIL dir_toggle_count[%0d] got %b want %b", i, count, exp_c[i]); else passed++;
            total++; if (wrap !== exp_w[i]) $display("FAIL dir_toggle_wrap[%0d] got %b want %b", i, wrap, exp_w[i]); else passed++;
        end
    endtask

    task automatic test_johnson();
        logic [3:0] exp_c [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
        mode = 1; en = 1; dir = 0;
        tick();
        total++; if (count !== 4'b0000) $display("FAIL johnson_switch_count got %b want 0000", count); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL johnson_switch_wrap got %b want 0", wrap); else passed++;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (count !== exp_c[i]) $display("FAIL johnson_count[%0d] got %b want %b", i, count, exp_c[i]); else passed++;
            total++; if (wrap !== (i == 7)) $display("FAIL johnson_wrap[%0d] got %b want %b", i, wrap, (i == 7)); else passed++;
        end
    endtask

    task automatic test_illegal();
        mode = 0; en = 0;
        tick();
        total++; if (count !== 4'b0001) $display("FAIL illegal_to_ring got %b want 0001", count); else passed++;
        load = 1; load_val = 4'b0101;
        tick();
        total++; if (count !== 4'b0101) $display("FAIL ring_load_count got %b want 0101", count); else passed++;
        total++; if (err !== 1'b0) $display("FAIL ring_load_err got %b want 0", err); else passed++;
        load = 0;
        tick();
        total++; if (count !== 4'b0001) $display("FAIL ring_fix_count got %b want 0001", count); else passed++;
        total++; if (err !== 1'b1) $display("FAIL ring_fix_err got %b want 1", err); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL ring_fix_wrap got %b want 0", wrap); else passed++;
        tick();
        total++; if (err !== 1'b0) $display("FAIL ring_fix_err_pulse got %b want 0", err); else passed++;
        mode = 1;
        tick();
        load = 1; load_val = 4'b0110;
        tick();
        total++; if (count !== 4'b0110) $display("FAIL john_load_count got %b want 0110", count); else passed++;
        load = 0;
        tick();
        total++; if (count !== 4'b0000) $display("FAIL john_fix_count got %b want 0000", count); else passed++;
        total++; if (err !== 1'b1) $display("FAIL john_fix_err got %b want 1", err); else passed++;
        tick();
        total++; if (err !== 1'b0) $display("FAIL john_fix_err_pulse got %b want 0", err); else passed++;
    endtask

    task automatic test_priority();
        mode = 0; en = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (count !== 4'b0001) $display("FAIL hold_count[%0d] got %b want 0001", i, count); else passed++;
        end
        rst = 1; load = 1; load_val = 4'b1000; en = 1;
        tick();
        total++; if (count !== 4'b0001) $display("FAIL rst_over_load got %b want 0001", count); else passed++;
        rst = 0; load = 0; dir = 0;
        tick(); tick();
        total++; if (count !== 4'b0100) $display("FAIL pre_mid_rst got %b want 0100", count); else passed++;
        rst = 1;
        tick();
        total++; if (count !== 4'b0001) $display("FAIL mid_sweep_rst got %b want 0001", count); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL mid_sweep_rst_wrap got %b want 0", wrap); else passed++;
        rst = 0; en = 0;
    endtask

    task automatic test_width8();
        int wraps;
        rst8 = 1; en8 = 0; mode8 = 0; dir8 = 0; load8 = 0; load_val8 = 8'h00;
        tick();
        rst8 = 0; en8 = 1;
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wrap8) wraps++;
            total++; if (count8 !== (8'h01 << ((i + 1) % 8))) $display("FAIL w8_ring_count[%0d] got %h want %h", i, count8, 8'h01 << ((i + 1) % 8)); else passed++;
        end
        total++; if (wraps !== 1) $display("FAIL w8_ring_wraps got %0d want 1", wraps); else passed++;
        mode8 = 1;
        tick();
        total++; if (count8 !== 8'h00) $display("FAIL w8_john_switch got %h want 00", count8); else passed++;
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wrap8) wraps++;
            if (i == 7) begin
                total++; if (count8 !== 8'hFF) $display("FAIL w8_john_half got %h want ff", count8); else passed++;
            end
        end
        total++; if (count8 !== 8'h00) $display("FAIL w8_john_end got %h want 00", count8); else passed++;
        total++; if (wraps !== 1) $display("FAIL w8_john_wraps got %0d want 1", wraps); else passed++;
        for (int i = 0; i < 100; i++) begin
            en8  = 1'($urandom_range(0, 1));
            dir8 = 1'($urandom_range(0, 1));
            if (i == 50) mode8 = 0;
            tick();
            total++; if (legal8 !== 1'b1 || err8 !== 1'b0) $display("FAIL w8_random_legal[%0d] got legal=%b err=%b count=%h want legal=1 err=0", i, legal8, err8, count8); else passed++;
        end
    endtask

    initial begin
        rst8 = 1; en8 = 0; mode8 = 0; dir8 = 0; load8 = 0; load_val8 = 8'h00;
        test_reset();
        test_ring_left();
        test_ring_right();
        test_dir_toggle();
        test_johnson();
        test_illegal();
        test_priority();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ring_counter_param.md
Name: ring_counter_param

Overview:
Parametrised successor to the fixed 4-bit ring counter. Supports any WIDTH, ring or Johnson (twisted-ring) mode, and left or right shift direction. Adds count enable, parallel load, a wrap pulse and automatic self-correction of illegal states. Used as a one-hot sequencer or phase generator in sequential blocks.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
RING_SEED, 1, reset/re-seed value in ring mode; must be one-hot and WIDTH bits wide.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  advance one step per clock while high
mode  input  1  0 = ring, 1 = Johnson
dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right)
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
count  output  WIDTH  registered counter state
wrap  output  1  registered one-cycle pulse when a step returns count to the seed
err  output  1  registered one-cycle pulse when an illegal state is corrected

Behaviour:
- Seed: RING_SEED in ring mode, all-zeros in Johnson mode.
- Reset: on a clk edge with rst=1, count = seed(mode), wrap = 0, err = 0, and mode_q = mode. Reset overrides every other input, including a simultaneous load.
- Priority each edge: rst > load > mode change > illegal-state correction > en step > hold.
- Load: count <= load_val, accepted verbatim even if illegal. wrap = 0, err = 0.
- Mode change (mode != mode_q, where mode_q is an internal registered copy): count <= seed(new mode). No step that cycle. wrap = 0, err = 0.
- Ring step:
  - left: count <= {count[W-2:0], count[W-1]}
  - right: count <= {count[0], count[W-1:1]}
- Johnson step:
  - left: count <= {count[W-2:0], ~count[W-1]}
  - right: count <= {~count[0], count[W-1:1]}
- Cycle length: WIDTH steps in ring mode, 2*WIDTH steps in Johnson mode. dir may change on any cycle; the next step uses the new direction.
- Legality:
  - ring: exactly one bit set.
  - Johnson: at most one i in 0..W-2 where count[i] != count[i+1], which gives exactly 2*WIDTH legal codes.
- Correction: if count is illegal for the current mode and no load or mode change occurs, the next edge sets count <= seed and err = 1 for that cycle, regardless of en. wrap is not asserted on a correction.
- wrap = 1 only in the cycle after an en step whose result equals seed(mode). Load, correction and reset never assert wrap.
- en = 0 with a legal state: count holds, wrap = 0, err = 0.
- All outputs are registered. Step latency is 1 cycle. There is no combinational path from inputs to outputs.

Decomposition:
- Package ring_counter_pkg holds:
  - constants MODE_RING = 1'b0, MODE_JOHNSON = 1'b1, DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
  - function seed_of(mode) returning the WIDTH-bit seed
- Sub-module ring_state_check is a combinational legality detector.
  - Parameter: WIDTH.
  - Inputs: count, mode. Output: legal.
  - Instantiated once, and reusable by the bench as a checker.

Test Plan:
- Reset and ring sweep (WIDTH = 4): rst = 1 for 2 cycles gives count = 0001, wrap = 0, err = 0. Release with en = 1, mode = 0, dir = 0 gives 0010, 0100, 1000, 0001, with wrap = 1 only in the 0001 cycle.
- Right shift: in ring mode from 0001 with dir = 1, count goes 1000, 0100, 0010, 0001, with wrap at 0001. Toggling dir mid-sweep reverses order on the next edge.
- Johnson mode: switch mode 0 to 1 while en = 1; the next count is 0000 with no wrap. Steps then give 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with wrap = 1 on the 8th step only.
- Illegal load and correction:
  - Ring mode: load 0101 gives count = 0101. The next edge (en = 0) gives count = 0001, err = 1 for exactly 1 cycle, wrap = 0.
  - Johnson mode: load 0110 gives count = 0110, then 0000 with err = 1.
- Priorities:
  - en = 0 holds count for 5 cycles.
  - rst = 1 together with load = 1, load_val = 1000 and en = 1 gives count = 0001.
  - rst asserted mid-sweep resets on the same edge.
- WIDTH = 8: the ring cycle is 8 steps and the Johnson cycle is 16 steps, each with exactly one wrap pulse per cycle. ring_state_check flags no state produced from a legal start across 100 random en/dir cycles.
